// File: rtl/pwm_sched_pkg.sv
// Shared types and constants for the PWM sample scheduler and its FIFO.
package pwm_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_e;

  localparam int UNDERRUN_W = 16;

  // Bits needed to hold an occupancy of 0..depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pwm_sample_fifo.sv
// Synchronous first-word-fall-through FIFO with flush, full/empty flags and level.
module pwm_sample_fifo
  import pwm_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 8,
  parameter int LW         = level_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_flush,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [LW-1:0]         o_level
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic                  w_push;
  logic                  w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Head is read combinationally so a pop and the new output share one edge.
  assign o_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/pwm_sample_scheduler.sv
// Buffers audio samples and hands exactly one to the PWM stage per frame,
// handling priming, underrun and enable/disable.
module pwm_sample_scheduler
  import pwm_sched_pkg::*;
#(
  parameter int DATA_WIDTH    = 12,
  parameter int COUNTER_WIDTH = 10,
  parameter int FIFO_DEPTH    = 8,
  parameter int PRIME_LEVEL   = FIFO_DEPTH / 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic [DATA_WIDTH-1:0]              s_data,
  input  logic                               s_valid,
  output logic                               s_ready,
  output logic [DATA_WIDTH-1:0]              pwm_data,
  output logic                               frame_tick,
  output logic [level_width(FIFO_DEPTH)-1:0] fifo_level,
  output logic [UNDERRUN_W-1:0]              underrun_cnt
);

  localparam int LW = level_width(FIFO_DEPTH);

  state_e                  r_state;
  logic [COUNTER_WIDTH-1:0] r_frame_cnt;
  logic [DATA_WIDTH-1:0]   r_pwm_data;
  logic [UNDERRUN_W-1:0]   r_underrun_cnt;

  logic                    w_frame_tick;
  logic                    w_full;
  logic                    w_empty;
  logic [LW-1:0]           w_level;
  logic [DATA_WIDTH-1:0]   w_head;
  logic                    w_primed;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_flush;

  assign w_frame_tick = &r_frame_cnt;
  assign w_primed     = (w_level >= LW'(PRIME_LEVEL));
  assign s_ready      = enable && !w_full && (r_state != IDLE);
  assign w_push       = s_valid && s_ready;
  assign w_pop        = enable && w_frame_tick &&
                        (((r_state == PRIME) && w_primed) ||
                         ((r_state == RUN) && !w_empty));
  // Flush wins over any push/pop in the cycle enable drops.
  assign w_flush      = (r_state == IDLE) || !enable;

  assign frame_tick   = w_frame_tick;
  assign fifo_level   = w_level;
  assign pwm_data     = r_pwm_data;
  assign underrun_cnt = r_underrun_cnt;

  pwm_sample_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .LW         (LW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_data  (s_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_frame_cnt    <= '0;
      r_pwm_data     <= '0;
      r_underrun_cnt <= '0;
    end else begin
      r_frame_cnt <= r_frame_cnt + COUNTER_WIDTH'(1);
      case (r_state)
        IDLE: begin
          if (w_frame_tick) begin
            r_pwm_data <= '0;
          end
          if (enable) begin
            r_state <= PRIME;
          end
        end
        PRIME: begin
          if (!enable) begin
            r_state <= IDLE;
            if (w_frame_tick) begin
              r_pwm_data <= '0;
            end
          end else if (w_frame_tick) begin
            if (w_primed) begin
              r_pwm_data <= w_head;
              r_state    <= RUN;
            end else begin
              r_pwm_data <= '0;
            end
          end
        end
        RUN: begin
          if (!enable) begin
            r_state <= IDLE;
            if (w_frame_tick) begin
              r_pwm_data <= '0;
            end
          end else if (w_frame_tick) begin
            if (!w_empty) begin
              r_pwm_data <= w_head;
            end else begin
              r_pwm_data <= '0;
              r_state    <= PRIME;
              if (r_underrun_cnt != '1) begin
                r_underrun_cnt <= r_underrun_cnt + UNDERRUN_W'(1);
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
